// File: rtl/load_queue_if.sv
// load_queue_if: dispatch, ROB and memory-side signals of the load queue.
// The slave modport is the queue itself; the master modport is whatever
// drives it (dispatch/ROB/memory model). Clock and reset stay plain ports.
interface load_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ROB_IX = 2,
  parameter int ADDR_W = 32
) ();
  localparam int ROB_W = ROB_IX + 1;
  localparam int ROB_N = 2 ** ROB_W;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                     flush_in;
  logic                     valid_input_in;
  logic [ADDR_W-1:0]        addr_in;
  logic [2:0]               funct3_in;
  logic [ROB_W-1:0]         rob_ix_in;
  logic                     ready_out;
  logic [ROB_N-1:0]         can_load_in;
  logic                     mem_valid_out;
  logic                     mem_ready_in;
  logic [ADDR_W-1:0]        mem_addr_out;
  logic [2:0]               mem_funct3_out;
  logic [ROB_W-1:0]         mem_rob_ix_out;
  logic [OCC_W-1:0]         occupancy_out;
  logic [DEPTH-1:0]         lq_valid_out;
  logic [DEPTH*ADDR_W-1:0]  lq_addr_out;
  logic [DEPTH*ROB_W-1:0]   lq_rob_ix_out;

  modport slave (
    input  flush_in, valid_input_in, addr_in, funct3_in, rob_ix_in,
           can_load_in, mem_ready_in,
    output ready_out, mem_valid_out, mem_addr_out, mem_funct3_out,
           mem_rob_ix_out, occupancy_out, lq_valid_out, lq_addr_out,
           lq_rob_ix_out
  );

  modport master (
    output flush_in, valid_input_in, addr_in, funct3_in, rob_ix_in,
           can_load_in, mem_ready_in,
    input  ready_out, mem_valid_out, mem_addr_out, mem_funct3_out,
           mem_rob_ix_out, occupancy_out, lq_valid_out, lq_addr_out,
           lq_rob_ix_out
  );
endinterface

// File: rtl/load_queue.sv
// load_queue: DEPTH-entry queue of pending loads between dispatch and the
// memory unit. A load issues once its ROB slot is marked loadable, through a
// registered valid/ready output stage.
// Optional feature: define LOAD_QUEUE_AGE_ORDER_EN for oldest-first
// selection; otherwise the lowest-index eligible entry issues.
module load_queue #(
  parameter int DEPTH  = 4,
  parameter int ROB_IX = 2,
  parameter int ADDR_W = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  load_queue_if.slave lq
);
  localparam int ROB_W = ROB_IX + 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    FREE = 1'b0,
    WAIT = 1'b1
  } entry_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        funct3;
    logic [ROB_W-1:0]  rob_ix;
  } entry_t;

  entry_state_e     state_q [DEPTH];
  entry_state_e     state_d [DEPTH];
  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];
  entry_t           stage_q;
  logic             stage_valid_q;

  logic [OCC_W-1:0] occ;
  logic [DEPTH-1:0] eligible;
  logic             free_found;
  logic [IDX_W-1:0] alloc_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             stage_load;
  logic             alloc;
  logic             issue;
  entry_t           new_entry;

`ifdef LOAD_QUEUE_AGE_ORDER_EN
  logic [IDX_W-1:0] rank_q [DEPTH];
  logic [IDX_W-1:0] rank_d [DEPTH];
  logic [IDX_W-1:0] best_rank;
  logic [IDX_W-1:0] new_rank;
`endif

  // Occupancy and lowest free slot, both from registered entry state only.
  always_comb begin
    // NOTE: every variable written here gets a value before any branch,
    // otherwise synthesis infers a latch to hold it.
    occ        = '0;
    free_found = 1'b0;
    alloc_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (state_q[i] == WAIT) begin
        occ = occ + OCC_W'(1);
      end else if (!free_found) begin
        free_found = 1'b1;
        alloc_idx  = IDX_W'(i);
      end
    end
  end

  // An entry may issue when it waits and the ROB marks its slot loadable.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < DEPTH; i++) begin
      eligible[i] = (state_q[i] == WAIT) && lq.can_load_in[entry_q[i].rob_ix];
    end
  end

`ifdef LOAD_QUEUE_AGE_ORDER_EN
  // Oldest-first: the eligible entry with the lowest age rank wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    best_rank = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && (!sel_found || rank_q[i] < best_rank)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_rank = rank_q[i];
      end
    end
  end
`else
  // Index order: the lowest-index eligible entry wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`endif

  assign lq.ready_out = (occ != OCC_W'(DEPTH));
  assign stage_load   = !stage_valid_q || lq.mem_ready_in;
  // Flush wins over both allocation and issue.
  assign alloc        = lq.valid_input_in && lq.ready_out && !lq.flush_in;
  assign issue        = stage_load && sel_found && !lq.flush_in;
  assign new_entry    = '{addr: lq.addr_in, funct3: lq.funct3_in, rob_ix: lq.rob_ix_in};

`ifdef LOAD_QUEUE_AGE_ORDER_EN
  // The newcomer ranks behind every entry that survives this edge.
  assign new_rank = IDX_W'(occ - OCC_W'(issue));
`endif

  // Next entry state: free the issued entry, fill the allocated one.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
`ifdef LOAD_QUEUE_AGE_ORDER_EN
    rank_d  = rank_q;
`endif
    if (lq.flush_in) begin
      for (int i = 0; i < DEPTH; i++) state_d[i] = FREE;
    end else begin
      if (issue) begin
        state_d[sel_idx] = FREE;
`ifdef LOAD_QUEUE_AGE_ORDER_EN
        // Younger entries close the gap left by the issued one.
        for (int i = 0; i < DEPTH; i++) begin
          if (state_q[i] == WAIT && rank_q[i] > rank_q[sel_idx]) begin
            rank_d[i] = rank_q[i] - IDX_W'(1);
          end
        end
`endif
      end
      // The allocated slot was FREE, so it never collides with sel_idx.
      if (alloc) begin
        state_d[alloc_idx] = WAIT;
        entry_d[alloc_idx] = new_entry;
`ifdef LOAD_QUEUE_AGE_ORDER_EN
        rank_d[alloc_idx]  = new_rank;
`endif
      end
    end
  end

  // Entry registers; fields are cleared on reset because lq_* exposes them.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      // NOTE: the entry array is reset element by element since its
      // contents are visible on the forwarding outputs right after reset.
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= FREE;
        entry_q[i] <= '0;
`ifdef LOAD_QUEUE_AGE_ORDER_EN
        rank_q[i]  <= '0;
`endif
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples the pre-edge values of the others.
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
        entry_q[i] <= entry_d[i];
`ifdef LOAD_QUEUE_AGE_ORDER_EN
        rank_q[i]  <= rank_d[i];
`endif
      end
    end
  end

  // Output stage: reload when empty or drained, hold under back-pressure.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stage_valid_q <= 1'b0;
      stage_q       <= '0;
    end else if (lq.flush_in) begin
      stage_valid_q <= 1'b0;
    end else if (stage_load) begin
      stage_valid_q <= sel_found;
      if (sel_found) stage_q <= entry_q[sel_idx];
    end
  end

  assign lq.mem_valid_out  = stage_valid_q;
  assign lq.mem_addr_out   = stage_q.addr;
  assign lq.mem_funct3_out = stage_q.funct3;
  assign lq.mem_rob_ix_out = stage_q.rob_ix;
  assign lq.occupancy_out  = occ;

  // Flattened per-entry view for the ROB's forwarding checks.
  always_comb begin
    lq.lq_valid_out  = '0;
    lq.lq_addr_out   = '0;
    lq.lq_rob_ix_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lq.lq_valid_out[i]                   = (state_q[i] == WAIT);
      lq.lq_addr_out[i*ADDR_W +: ADDR_W]   = entry_q[i].addr;
      lq.lq_rob_ix_out[i*ROB_W +: ROB_W]   = entry_q[i].rob_ix;
    end
  end
endmodule
